password_bank: RTL
==================

Name: password_bank

Overview:
- Parametrised store of per-user numeric (BCD) passwords for the door security system.
- Next generation of the fixed 10-user, 4-digit set-password register:
  - user count and digit count are generic;
  - one-hot switch writes are replaced by a guarded change-password sequence (old → new → confirm);
  - adds a registered verify port for the unlock path and a timed lockout after repeated failures.
- Sits between the keypad/digit-entry logic and the door unlock/display logic.

Parameters:
- NUM_USERS, 10, number of user slots; must satisfy NUM_USERS ≤ 10^NUM_DIGITS − 1.
- NUM_DIGITS, 4, BCD digits per password.
- TIMEOUT_CYC, 1000, clock cycles allowed between steps of a change sequence.
- MAX_FAIL, 3, consecutive failures that trigger lockout.
- LOCK_CYC, 5000, lockout duration in cycles.
- Derived: UW = clog2(NUM_USERS); PW = 4*NUM_DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- user_sel  in  UW  selected user index, 0-based.
- digits_in  in  PW  entered digits, digit 0 in bits [3:0].
- chk_req  in  1  one-cycle pulse: compare digits_in with the password of user_sel.
- set_req  in  1  one-cycle pulse: submit digits_in as the next step of the change sequence.
- cancel  in  1  abort the change sequence.
- chk_ok  out  1  one-cycle pulse: verify matched.
- chk_bad  out  1  one-cycle pulse: verify mismatched, or rejected.
- set_done  out  1  one-cycle pulse: new password committed.
- set_fail  out  1  one-cycle pulse: change step failed.
- busy  out  1  high in every state except IDLE.
- locked  out  1  high while in LOCKED.
- p_wordset  out  1  sticky: at least one password committed since reset.

Behaviour:
- Reset (asynchronous):
  - password of user i = BCD of (i+1), e.g. user 0 = 0001, user 9 = 0010;
  - all pulse outputs, busy, locked and p_wordset = 0;
  - fail counter = 0; FSM = IDLE.
- Verify:
  - chk_req in IDLE or in any wait state → exactly one of chk_ok/chk_bad on the next cycle.
  - chk_bad if user_sel ≥ NUM_USERS or the compare mismatches.
  - chk_req in LOCKED → chk_bad and no comparison.
  - A verify mismatch counts as a failure; chk_ok clears the fail counter.
- FSM states: IDLE, WAIT_NEW, WAIT_CONF, LOCKED.
- IDLE + set_req (old password step):
  - user_sel valid and digits_in == stored → latch user_sel as tgt_user; go to WAIT_NEW.
  - otherwise → set_fail.
- WAIT_NEW + set_req:
  - all digits ≤ 9 → latch digits_in into tmp_pw; go to WAIT_CONF.
  - any digit > 9 → set_fail; go to IDLE.
- WAIT_CONF + set_req:
  - digits_in == tmp_pw → write tmp_pw to stored[tgt_user], set_done, p_wordset ← 1, clear fail counter; go to IDLE.
  - otherwise → set_fail; go to IDLE.
- Latency: every response pulse appears 1 cycle after its request; the stored value is visible to chk_req from the cycle after set_done.
- user_sel is ignored in the wait states; tgt_user is authoritative.
- Timeout:
  - a timer runs in WAIT_NEW and WAIT_CONF and reloads on each accepted step;
  - reaching TIMEOUT_CYC → set_fail; go to IDLE.
- cancel in a wait state → IDLE with no pulse; it is not counted as a failure and takes priority over a simultaneous set_req.
- Failures:
  - every set_fail and chk_bad increments the fail counter, which saturates at MAX_FAIL;
  - reaching MAX_FAIL → LOCKED.
- LOCKED:
  - set_req and cancel are ignored, with no pulses;
  - after LOCK_CYC cycles → IDLE and the fail counter clears.
- chk_req and set_req in the same cycle: set_req is processed; chk_req returns chk_bad and is not counted as a failure.
- Reset mid-sequence: tmp_pw is discarded and all passwords return to their defaults.

Decomposition:
- Shared package password_pkg holds:
  - the FSM state enum;
  - the BCD digit type;
  - a function default_pw(idx, ndigits) returning the BCD password for index idx;
  - a function bcd_valid(vec).
- One sub-module, pw_timer: a loadable down-counter used for both the timeout and the lockout.

Test Plan:
- Reset, then chk_req for users 0, 8 and 9 with 0001, 0009 and 0010 → chk_ok on each, one cycle later.
- Full change for user 2: old 0003, new 4711, confirm 4711 → set_done and p_wordset=1; chk 4711 → chk_ok; chk 0003 → chk_bad.
- Confirm mismatch: old ok, new 1234, confirm 1235 → set_fail; user password still 0003.
- New password with digit 1 = 0xA → set_fail in WAIT_NEW and the FSM returns to IDLE.
- After WAIT_NEW is entered, idle for TIMEOUT_CYC → set_fail; a separate run asserts cancel → IDLE with no pulse.
- Three consecutive bad checks → locked=1 for exactly LOCK_CYC cycles; a valid chk_req during lockout → chk_bad; after lockout a valid chk_req → chk_ok.

Source files
------------

// File: rtl/password_pkg.sv
// rtl/password_pkg.sv - shared types and helpers for the password bank
package password_pkg;

  localparam int MAX_PW = 64;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_NEW,
    ST_WAIT_CONF,
    ST_LOCKED
  } pw_state_t;

  function automatic logic [MAX_PW-1:0] default_pw(input int idx, input int ndigits);
    logic [MAX_PW-1:0] res;
    int v;
    res = '0;
    v   = idx + 1;
    for (int d = 0; d < MAX_PW/4; d++) begin
      if (d < ndigits) begin
        res[4*d +: 4] = bcd_t'(v % 10);
        v = v / 10;
      end
    end
    return res;
  endfunction

  // Zero-extended inputs stay valid: the padding nibbles are legal digits.
  function automatic logic bcd_valid(input logic [MAX_PW-1:0] vec);
    logic ok;
    bcd_t dig;
    ok = 1'b1;
    for (int d = 0; d < MAX_PW/4; d++) begin
      dig = vec[4*d +: 4];
      if (dig > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/pw_timer.sv
// rtl/pw_timer.sv - loadable down-counter shared by step timeout and lockout
module pw_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of N fires on the N-th edge after the load edge.
  assign expired = (count_q == CW'(1));

endmodule

// File: rtl/password_bank.sv
// rtl/password_bank.sv - per-user BCD password store with guarded change and lockout
module password_bank
  import password_pkg::*;
#(
  parameter  int NUM_USERS   = 10,
  parameter  int NUM_DIGITS  = 4,
  parameter  int TIMEOUT_CYC = 1000,
  parameter  int MAX_FAIL    = 3,
  parameter  int LOCK_CYC    = 5000,
  localparam int UW          = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
  localparam int PW          = 4 * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [UW-1:0] user_sel,
  input  logic [PW-1:0] digits_in,
  input  logic          chk_req,
  input  logic          set_req,
  input  logic          cancel,
  output logic          chk_ok,
  output logic          chk_bad,
  output logic          set_done,
  output logic          set_fail,
  output logic          busy,
  output logic          locked,
  output logic          p_wordset
);

  localparam int TMAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);

  pw_state_t     state_q, state_d;
  logic [PW-1:0] pw_q [NUM_USERS];
  logic [PW-1:0] pw_d [NUM_USERS];
  logic [PW-1:0] tmp_pw_q, tmp_pw_d;
  logic [UW-1:0] tgt_user_q, tgt_user_d;
  logic [FW-1:0] fail_cnt_q, fail_cnt_d;
  logic          chk_ok_q, chk_ok_d;
  logic          chk_bad_q, chk_bad_d;
  logic          set_done_q, set_done_d;
  logic          set_fail_q, set_fail_d;
  logic          p_wordset_q, p_wordset_d;

  logic          user_ok;
  logic [PW-1:0] stored_sel;
  logic          pw_match;
  logic          chk_fail;
  logic          fail_clr;
  int            fail_sum;
  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          timer_expired;

  pw_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  assign user_ok = (32'(user_sel) < NUM_USERS);

  always_comb begin
    stored_sel = '0;
    if (user_ok) stored_sel = pw_q[user_sel];
  end

  assign pw_match = user_ok && (digits_in == stored_sel);

  always_comb begin
    state_d     = state_q;
    pw_d        = pw_q;
    tmp_pw_d    = tmp_pw_q;
    tgt_user_d  = tgt_user_q;
    chk_ok_d    = 1'b0;
    chk_bad_d   = 1'b0;
    set_done_d  = 1'b0;
    set_fail_d  = 1'b0;
    p_wordset_d = p_wordset_q;
    chk_fail    = 1'b0;
    fail_clr    = 1'b0;
    timer_load  = 1'b0;
    timer_val   = CW'(TIMEOUT_CYC);
    fail_cnt_d  = fail_cnt_q;
    fail_sum    = 0;

    // A check colliding with a set step, or arriving while locked, is refused uncounted.
    if (chk_req) begin
      if (state_q == ST_LOCKED || set_req) begin
        chk_bad_d = 1'b1;
      end else if (pw_match) begin
        chk_ok_d = 1'b1;
        fail_clr = 1'b1;
      end else begin
        chk_bad_d = 1'b1;
        chk_fail  = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (set_req) begin
          if (pw_match) begin
            tgt_user_d = user_sel;
            state_d    = ST_WAIT_NEW;
            timer_load = 1'b1;
          end else begin
            set_fail_d = 1'b1;
          end
        end
      end
      ST_WAIT_NEW: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (set_req) begin
          if (bcd_valid(MAX_PW'(digits_in))) begin
            tmp_pw_d   = digits_in;
            state_d    = ST_WAIT_CONF;
            timer_load = 1'b1;
          end else begin
            set_fail_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (timer_expired) begin
          set_fail_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT_CONF: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (set_req) begin
          if (digits_in == tmp_pw_q) begin
            pw_d[tgt_user_q] = tmp_pw_q;
            set_done_d       = 1'b1;
            p_wordset_d      = 1'b1;
            fail_clr         = 1'b1;
          end else begin
            set_fail_d = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          set_fail_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (timer_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_LOCKED) begin
      fail_cnt_d = timer_expired ? '0 : fail_cnt_q;
    end else begin
      fail_sum = (fail_clr ? 0 : int'(fail_cnt_q)) + int'(chk_fail) + int'(set_fail_d);
      if ((chk_fail || set_fail_d) && fail_sum >= MAX_FAIL) begin
        fail_cnt_d = FW'(MAX_FAIL);
        state_d    = ST_LOCKED;
        timer_load = 1'b1;
        timer_val  = CW'(LOCK_CYC);
      end else begin
        fail_cnt_d = FW'(fail_sum);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_USERS; i++) begin
        pw_q[i] <= PW'(default_pw(i, NUM_DIGITS));
      end
      tmp_pw_q    <= '0;
      tgt_user_q  <= '0;
      fail_cnt_q  <= '0;
      chk_ok_q    <= 1'b0;
      chk_bad_q   <= 1'b0;
      set_done_q  <= 1'b0;
      set_fail_q  <= 1'b0;
      p_wordset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      tmp_pw_q    <= tmp_pw_d;
      tgt_user_q  <= tgt_user_d;
      fail_cnt_q  <= fail_cnt_d;
      chk_ok_q    <= chk_ok_d;
      chk_bad_q   <= chk_bad_d;
      set_done_q  <= set_done_d;
      set_fail_q  <= set_fail_d;
      p_wordset_q <= p_wordset_d;
    end
  end

  assign chk_ok    = chk_ok_q;
  assign chk_bad   = chk_bad_q;
  assign set_done  = set_done_q;
  assign set_fail  = set_fail_q;
  assign p_wordset = p_wordset_q;
  assign busy      = (state_q != ST_IDLE);
  assign locked    = (state_q == ST_LOCKED);

endmodule
